// File: rtl/key_loader_pkg.sv
// Shared types and constants for the serial key loader.
// Optional feature macro: KEY_PARITY_EN (trailing even-parity bit).
package key_loader_pkg;

    typedef enum logic [2:0] {
        KL_IDLE  = 3'd0,
        KL_SHIFT = 3'd1,
        KL_PAR   = 3'd2,
        KL_READY = 3'd3,
        KL_ERROR = 3'd4
    } kl_state_t;

    localparam int KL_KEY_W_DEFAULT = 8;

    // XOR over key bits plus parity bit that marks an accepted key (even parity)
    localparam logic KL_PARITY_POL = 1'b0;

endpackage

// File: rtl/key_loader_if.sv
// Key-provisioning bus between key storage, the loader and the locked controller.
// Optional feature macro: KEY_PARITY_EN (drives key_err when defined).
interface key_loader_if
    import key_loader_pkg::*;
#(
    parameter int KEY_W = KL_KEY_W_DEFAULT
);

    logic             load_start;
    logic             key_sdi;
    logic             key_sdi_valid;
    logic [KEY_W-1:0] key_out;
    logic             key_ready;
    logic             fsm_rst;
    logic             busy;
    logic             key_err;

    modport master (
        output load_start, key_sdi, key_sdi_valid,
        input  key_out, key_ready, fsm_rst, busy, key_err
    );

    modport slave (
        input  load_start, key_sdi, key_sdi_valid,
        output key_out, key_ready, fsm_rst, busy, key_err
    );

endinterface

// File: rtl/key_shift_reg.sv
// Shadow register collecting serial key bits at an explicit bit index.
// Optional feature macro: KEY_PARITY_EN (no effect on this block).
module key_shift_reg
    import key_loader_pkg::*;
#(
    parameter int KEY_W = KL_KEY_W_DEFAULT,
    parameter int CNT_W = $clog2(KEY_W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_idx,
    input  logic             i_bit,
    output logic [KEY_W-1:0] o_shadow
);

    logic [KEY_W-1:0] r_shadow;

    // Index decode by compare keeps the counter width independent of KEY_W
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_shadow <= '0;
        end else if (i_en) begin
            for (int i = 0; i < KEY_W; i++) begin
                if (i_idx == CNT_W'(i)) begin
                    r_shadow[i] <= i_bit;
                end
            end
        end
    end

    assign o_shadow = r_shadow;

endmodule

// File: rtl/key_loader.sv
// Serial key loader: shifts a key in LSB first, commits it in parallel and holds
// the locked controller in reset until a complete key is present. Macro: KEY_PARITY_EN.
module key_loader
    import key_loader_pkg::*;
#(
    parameter int KEY_W = KL_KEY_W_DEFAULT,
    parameter int CNT_W = $clog2(KEY_W + 1)
) (
    input  logic         clk,
    input  logic         rst,
    key_loader_if.slave  kl_if
);

    localparam logic [2:0] S_IDLE  = KL_IDLE;
    localparam logic [2:0] S_SHIFT = KL_SHIFT;
    localparam logic [2:0] S_READY = KL_READY;
`ifdef KEY_PARITY_EN
    localparam logic [2:0] S_PAR   = KL_PAR;
    localparam logic [2:0] S_ERROR = KL_ERROR;
`endif

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_count;
    logic [KEY_W-1:0] r_key_out;
    logic             r_key_ready;
    logic             r_fsm_rst;
    logic             r_busy;
    logic [KEY_W-1:0] w_shadow;
    logic             w_shift_en;
    logic             w_last;

    // A restart in the same cycle as a valid bit discards that bit
    assign w_shift_en = (r_state == S_SHIFT) && kl_if.key_sdi_valid && !kl_if.load_start;
    assign w_last     = (r_count == CNT_W'(KEY_W - 1));

    key_shift_reg #(
        .KEY_W (KEY_W),
        .CNT_W (CNT_W)
    ) u_shift (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (kl_if.load_start),
        .i_en     (w_shift_en),
        .i_idx    (r_count),
        .i_bit    (kl_if.key_sdi),
        .o_shadow (w_shadow)
    );

`ifdef KEY_PARITY_EN
    logic r_key_err;
    logic w_par_xor;
    assign w_par_xor = (^w_shadow) ^ kl_if.key_sdi;
`else
    // Last bit is still in flight into the shadow register on the commit edge
    logic [KEY_W-1:0] w_commit;
    always_comb begin
        w_commit            = w_shadow;
        w_commit[KEY_W-1]   = kl_if.key_sdi;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_count     <= '0;
            r_key_out   <= '0;
            r_key_ready <= 1'b0;
            r_fsm_rst   <= 1'b1;
            r_busy      <= 1'b0;
`ifdef KEY_PARITY_EN
            r_key_err   <= 1'b0;
`endif
        end else if (kl_if.load_start) begin
            r_state     <= S_SHIFT;
            r_count     <= '0;
            r_key_out   <= '0;
            r_key_ready <= 1'b0;
            r_fsm_rst   <= 1'b1;
            r_busy      <= 1'b1;
`ifdef KEY_PARITY_EN
            r_key_err   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_SHIFT: begin
                    if (kl_if.key_sdi_valid) begin
                        r_count <= r_count + CNT_W'(1);
                        if (w_last) begin
`ifdef KEY_PARITY_EN
                            r_state     <= S_PAR;
`else
                            r_state     <= S_READY;
                            r_key_out   <= w_commit;
                            r_key_ready <= 1'b1;
                            r_busy      <= 1'b0;
`endif
                        end
                    end
                end
`ifdef KEY_PARITY_EN
                S_PAR: begin
                    if (kl_if.key_sdi_valid) begin
                        r_busy <= 1'b0;
                        if (w_par_xor == KL_PARITY_POL) begin
                            r_state     <= S_READY;
                            r_key_out   <= w_shadow;
                            r_key_ready <= 1'b1;
                        end else begin
                            r_state     <= S_ERROR;
                            r_key_err   <= 1'b1;
                        end
                    end
                end
`endif
                // Release on the second READY cycle so key_out is stable for a full cycle
                S_READY: r_fsm_rst <= 1'b0;
                default: ;
            endcase
        end
    end

    assign kl_if.key_out   = r_key_out;
    assign kl_if.key_ready = r_key_ready;
    assign kl_if.fsm_rst   = r_fsm_rst;
    assign kl_if.busy      = r_busy;
`ifdef KEY_PARITY_EN
    assign kl_if.key_err   = r_key_err;
`else
    assign kl_if.key_err   = 1'b0;
`endif

endmodule

// File: tb/tb_key_loader.sv
// Scoreboard bench for key_loader; parity scenarios run when KEY_PARITY_EN is defined.
module tb_key_loader;
    import key_loader_pkg::*;

    localparam int KEY_W = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    key_loader_if #(.KEY_W(KEY_W)) kl_if ();

    key_loader #(.KEY_W(KEY_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .kl_if (kl_if)
    );

    int n_vec = 0;
    int n_err = 0;
    logic [KEY_W-1:0] exp_q[$];
    logic [KEY_W-1:0] exp_key;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load();
        kl_if.load_start = 1'b1;
        tick();
        kl_if.load_start = 1'b0;
    endtask

    task automatic drive_bits(input logic [KEY_W-1:0] key, input int first, input int last, input bit stall);
        for (int i = first; i <= last; i++) begin
            if (stall) begin
                kl_if.key_sdi_valid = 1'b0;
                kl_if.key_sdi       = ~key[i];
                tick();
            end
            kl_if.key_sdi       = key[i];
            kl_if.key_sdi_valid = 1'b1;
            tick();
        end
        kl_if.key_sdi_valid = 1'b0;
    endtask

    task automatic send_parity(input logic [KEY_W-1:0] key, input bit flip);
        kl_if.key_sdi = (^key) ^ flip;
`ifdef KEY_PARITY_EN
        kl_if.key_sdi_valid = 1'b1;
        tick();
        kl_if.key_sdi_valid = 1'b0;
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_vec++; if (kl_if.key_out !== 8'h00) begin n_err++; $display("FAIL reset_key_out: got %h expected %h", kl_if.key_out, 8'h00); end
        n_vec++; if (kl_if.key_ready !== 1'b0) begin n_err++; $display("FAIL reset_key_ready: got %b expected 0", kl_if.key_ready); end
        n_vec++; if (kl_if.fsm_rst !== 1'b1) begin n_err++; $display("FAIL reset_fsm_rst: got %b expected 1", kl_if.fsm_rst); end
        n_vec++; if (kl_if.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", kl_if.busy); end
        n_vec++; if (kl_if.key_err !== 1'b0) begin n_err++; $display("FAIL reset_key_err: got %b expected 0", kl_if.key_err); end
    endtask

    task automatic test_basic();
        start_load();
        n_vec++; if (kl_if.busy !== 1'b1) begin n_err++; $display("FAIL basic_busy: got %b expected 1", kl_if.busy); end
        exp_q.push_back(8'hA5);
        drive_bits(8'hA5, 0, KEY_W - 2, 1'b0);
        n_vec++; if (kl_if.key_ready !== 1'b0) begin n_err++; $display("FAIL basic_early_ready: got %b expected 0", kl_if.key_ready); end
        n_vec++; if (kl_if.key_out !== 8'h00) begin n_err++; $display("FAIL basic_early_key: got %h expected %h", kl_if.key_out, 8'h00); end
        drive_bits(8'hA5, KEY_W - 1, KEY_W - 1, 1'b0);
        send_parity(8'hA5, 1'b0);
        exp_key = exp_q.pop_front();
        n_vec++; if (kl_if.key_out !== exp_key) begin n_err++; $display("FAIL basic_key: got %h expected %h", kl_if.key_out, exp_key); end
        n_vec++; if (kl_if.key_ready !== 1'b1) begin n_err++; $display("FAIL basic_ready: got %b expected 1", kl_if.key_ready); end
        n_vec++; if (kl_if.busy !== 1'b0) begin n_err++; $display("FAIL basic_busy_done: got %b expected 0", kl_if.busy); end
        n_vec++; if (kl_if.fsm_rst !== 1'b1) begin n_err++; $display("FAIL basic_fsm_rst_hold: got %b expected 1", kl_if.fsm_rst); end
        n_vec++; if (kl_if.key_err !== 1'b0) begin n_err++; $display("FAIL basic_key_err: got %b expected 0", kl_if.key_err); end
        tick();
        n_vec++; if (kl_if.fsm_rst !== 1'b0) begin n_err++; $display("FAIL basic_fsm_rst_release: got %b expected 0", kl_if.fsm_rst); end
        n_vec++; if (kl_if.key_out !== exp_key) begin n_err++; $display("FAIL basic_key_stable: got %h expected %h", kl_if.key_out, exp_key); end
    endtask

    task automatic test_reload();
        start_load();
        n_vec++; if (kl_if.key_ready !== 1'b0) begin n_err++; $display("FAIL reload_ready: got %b expected 0", kl_if.key_ready); end
        n_vec++; if (kl_if.fsm_rst !== 1'b1) begin n_err++; $display("FAIL reload_fsm_rst: got %b expected 1", kl_if.fsm_rst); end
        n_vec++; if (kl_if.key_out !== 8'h00) begin n_err++; $display("FAIL reload_key_clear: got %h expected %h", kl_if.key_out, 8'h00); end
        n_vec++; if (kl_if.busy !== 1'b1) begin n_err++; $display("FAIL reload_busy: got %b expected 1", kl_if.busy); end
        exp_q.push_back(8'h5A);
        drive_bits(8'h5A, 0, KEY_W - 1, 1'b0);
        send_parity(8'h5A, 1'b0);
        exp_key = exp_q.pop_front();
        n_vec++; if (kl_if.key_out !== exp_key) begin n_err++; $display("FAIL reload_key: got %h expected %h", kl_if.key_out, exp_key); end
        tick();
        n_vec++; if (kl_if.fsm_rst !== 1'b0) begin n_err++; $display("FAIL reload_fsm_rst_release: got %b expected 0", kl_if.fsm_rst); end
    endtask

    task automatic test_stall();
        start_load();
        exp_q.push_back(8'h3C);
        for (int i = 0; i < KEY_W - 1; i++) begin
            drive_bits(8'h3C, i, i, 1'b1);
            n_vec++; if (kl_if.key_out !== 8'h00) begin n_err++; $display("FAIL stall_key_early bit%0d: got %h expected %h", i, kl_if.key_out, 8'h00); end
        end
        n_vec++; if (kl_if.key_ready !== 1'b0) begin n_err++; $display("FAIL stall_early_ready: got %b expected 0", kl_if.key_ready); end
        drive_bits(8'h3C, KEY_W - 1, KEY_W - 1, 1'b1);
        send_parity(8'h3C, 1'b0);
        exp_key = exp_q.pop_front();
        n_vec++; if (kl_if.key_out !== exp_key) begin n_err++; $display("FAIL stall_key: got %h expected %h", kl_if.key_out, exp_key); end
        n_vec++; if (kl_if.key_ready !== 1'b1) begin n_err++; $display("FAIL stall_ready: got %b expected 1", kl_if.key_ready); end
    endtask

    task automatic test_restart();
        start_load();
        drive_bits(8'hFF, 0, 4, 1'b0);
        kl_if.load_start    = 1'b1;
        kl_if.key_sdi       = 1'b1;
        kl_if.key_sdi_valid = 1'b1;
        tick();
        kl_if.load_start    = 1'b0;
        kl_if.key_sdi_valid = 1'b0;
        n_vec++; if (kl_if.busy !== 1'b1) begin n_err++; $display("FAIL restart_busy: got %b expected 1", kl_if.busy); end
        exp_q.push_back(8'h0F);
        drive_bits(8'h0F, 0, KEY_W - 2, 1'b0);
        n_vec++; if (kl_if.key_ready !== 1'b0) begin n_err++; $display("FAIL restart_early_ready: got %b expected 0", kl_if.key_ready); end
        drive_bits(8'h0F, KEY_W - 1, KEY_W - 1, 1'b0);
        send_parity(8'h0F, 1'b0);
        exp_key = exp_q.pop_front();
        n_vec++; if (kl_if.key_out !== exp_key) begin n_err++; $display("FAIL restart_key: got %h expected %h", kl_if.key_out, exp_key); end
        n_vec++; if (kl_if.key_ready !== 1'b1) begin n_err++; $display("FAIL restart_ready: got %b expected 1", kl_if.key_ready); end
    endtask

    task automatic test_reset_mid();
        start_load();
        drive_bits(8'hA5, 0, 2, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_vec++; if (dut.r_state !== 3'(KL_IDLE)) begin n_err++; $display("FAIL midrst_state: got %0d expected %0d", dut.r_state, 3'(KL_IDLE)); end
        n_vec++; if (kl_if.key_out !== 8'h00) begin n_err++; $display("FAIL midrst_key: got %h expected %h", kl_if.key_out, 8'h00); end
        n_vec++; if (kl_if.fsm_rst !== 1'b1) begin n_err++; $display("FAIL midrst_fsm_rst: got %b expected 1", kl_if.fsm_rst); end
        n_vec++; if (kl_if.busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b expected 0", kl_if.busy); end
        rst = 1'b1;
        kl_if.load_start = 1'b1;
        tick();
        rst = 1'b0;
        kl_if.load_start = 1'b0;
        n_vec++; if (kl_if.busy !== 1'b0) begin n_err++; $display("FAIL rst_vs_load_busy: got %b expected 0", kl_if.busy); end
        n_vec++; if (dut.r_state !== 3'(KL_IDLE)) begin n_err++; $display("FAIL rst_vs_load_state: got %0d expected %0d", dut.r_state, 3'(KL_IDLE)); end
    endtask

`ifdef KEY_PARITY_EN
    task automatic test_parity();
        start_load();
        exp_q.push_back(8'hA5);
        drive_bits(8'hA5, 0, KEY_W - 1, 1'b0);
        n_vec++; if (kl_if.key_ready !== 1'b0) begin n_err++; $display("FAIL par_wait_ready: got %b expected 0", kl_if.key_ready); end
        n_vec++; if (kl_if.busy !== 1'b1) begin n_err++; $display("FAIL par_wait_busy: got %b expected 1", kl_if.busy); end
        send_parity(8'hA5, 1'b0);
        exp_key = exp_q.pop_front();
        n_vec++; if (kl_if.key_out !== exp_key) begin n_err++; $display("FAIL par_ok_key: got %h expected %h", kl_if.key_out, exp_key); end
        n_vec++; if (kl_if.key_err !== 1'b0) begin n_err++; $display("FAIL par_ok_err: got %b expected 0", kl_if.key_err); end
        start_load();
        exp_q.push_back(8'h00);
        drive_bits(8'hA5, 0, KEY_W - 1, 1'b0);
        send_parity(8'hA5, 1'b1);
        exp_key = exp_q.pop_front();
        n_vec++; if (kl_if.key_err !== 1'b1) begin n_err++; $display("FAIL par_bad_err: got %b expected 1", kl_if.key_err); end
        n_vec++; if (kl_if.key_out !== exp_key) begin n_err++; $display("FAIL par_bad_key: got %h expected %h", kl_if.key_out, exp_key); end
        n_vec++; if (kl_if.key_ready !== 1'b0) begin n_err++; $display("FAIL par_bad_ready: got %b expected 0", kl_if.key_ready); end
        n_vec++; if (kl_if.busy !== 1'b0) begin n_err++; $display("FAIL par_bad_busy: got %b expected 0", kl_if.busy); end
        tick();
        tick();
        tick();
        n_vec++; if (kl_if.fsm_rst !== 1'b1) begin n_err++; $display("FAIL par_bad_fsm_rst: got %b expected 1", kl_if.fsm_rst); end
        start_load();
        n_vec++; if (kl_if.key_err !== 1'b0) begin n_err++; $display("FAIL par_reload_err_clear: got %b expected 0", kl_if.key_err); end
        exp_q.push_back(8'h5A);
        drive_bits(8'h5A, 0, KEY_W - 1, 1'b0);
        send_parity(8'h5A, 1'b0);
        exp_key = exp_q.pop_front();
        n_vec++; if (kl_if.key_out !== exp_key) begin n_err++; $display("FAIL par_reload_key: got %h expected %h", kl_if.key_out, exp_key); end
        tick();
        n_vec++; if (kl_if.fsm_rst !== 1'b0) begin n_err++; $display("FAIL par_reload_fsm_rst: got %b expected 0", kl_if.fsm_rst); end
    endtask
`endif

    initial begin
        rst                 = 1'b1;
        kl_if.load_start    = 1'b0;
        kl_if.key_sdi       = 1'b0;
        kl_if.key_sdi_valid = 1'b0;
        test_reset();
        test_basic();
        test_reload();
        test_stall();
        test_restart();
        test_reset_mid();
`ifdef KEY_PARITY_EN
        test_parity();
`endif
        n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/key_loader.md
# key_loader

Upstream key-provisioning stage for the locked controller benchmarks. It shifts a serial key in from the key-storage interface, one bit per qualified cycle, LSB first. It commits the full key in parallel on `key_out` only once complete and, when configured, parity-checked. It holds the downstream locked controller in reset until a valid key is present, so the controller never runs with a partial or corrupt key.

## Interface
- `KEY_W`, default 8: key width in bits, legal range 1..64.
- `CNT_W`, default `$clog2(KEY_W+1)`: bit-counter width; derived, not overridden.
- `clk` input 1: single clock; all state updates on posedge.
- `rst` input 1: reset, synchronous, active-high.
- `load_start` input 1: pulse that starts or restarts a key load.
- `key_sdi` input 1: serial key data.
- `key_sdi_valid` input 1: `key_sdi` is qualified this cycle.
- `key_out` output KEY_W: committed key, fed to the locked controller's `keyinput*` pins.
- `key_ready` output 1: `key_out` holds a complete, accepted key.
- `fsm_rst` output 1: reset to the downstream controller, active-high.
- `busy` output 1: a load is in progress.
- `key_err` output 1: last load failed its parity check. Always 0 without `KEY_PARITY_EN`.

## Operation
- States:
  - IDLE: no key.
  - SHIFT: collecting key bits.
  - PAR: collecting the parity bit; exists only with the macro.
  - READY: key committed.
  - ERROR: parity failed; exists only with the macro.
- Reset values: state IDLE, shadow register 0, counter 0, `key_out` 0, `key_ready` 0, `fsm_rst` 1, `busy` 0, `key_err` 0.
- IDLE, READY or ERROR, on `load_start`=1 → SHIFT:
  - counter and shadow cleared;
  - `key_ready` 0, `key_err` 0, `busy` 1;
  - `key_out` cleared to 0.
- SHIFT, on `key_sdi_valid`=1:
  - `shadow[count] <= key_sdi`; count += 1.
  - On the edge that samples bit KEY_W-1: go to READY (no macro) or PAR (macro).
  - Cycles with `key_sdi_valid`=0 are stalls; there is no timeout.
- PAR, on `key_sdi_valid`=1: even parity over shadow and the parity bit.
  - XOR = 0 → READY.
  - XOR = 1 → ERROR.
- Entry to READY: `key_out <= shadow`, `key_ready` 1, `busy` 0.
- Entry to ERROR: `key_out` stays 0, `key_err` 1, `busy` 0, `fsm_rst` stays 1.
- `load_start` in SHIFT or PAR restarts the load: counter and shadow cleared. A `key_sdi_valid` arriving in the same cycle is discarded; restart wins.
- `load_start` and `rst` in the same cycle: reset wins.
- `fsm_rst` is 0 only in READY, and only from the second cycle of READY onward, so the key is stable for one full cycle before the controller leaves reset.
- `key_out` never changes while `fsm_rst` is 0.

## Timing
- `load_start` sampled at edge E0 → `busy`=1 after E0.
- Bits are sampled at edges at or after E1.
- Last data bit (no macro) or parity bit (macro) sampled at edge Et → `key_out` and `key_ready` valid after Et; `fsm_rst` falls after Et+1.
- Minimum load with no stalls: KEY_W+1 edges to `key_ready` (+1 with the macro); `fsm_rst` releases one edge later.
- All outputs are registered; there are no combinational paths from input to output.

## Configuration
- `KEY_PARITY_EN` defined:
  - one trailing even-parity bit is expected after the key;
  - PAR and ERROR states and `key_err` logic are present;
  - a mismatch blocks the key, and the controller stays in reset until a successful reload.
- Not defined:
  - PAR and ERROR are absent;
  - `key_err` is tied to 0;
  - READY follows the last data bit directly.

## Structure
- Package `key_loader_pkg` holds:
  - the state enum `kl_state_t` (IDLE, SHIFT, PAR, READY, ERROR);
  - the default `KEY_W`;
  - the parity-polarity constant.
- One sub-module, `key_shift_reg`: shadow register with clear, shift-enable and bit index. The FSM, counter and commit logic stay in `key_loader`.

## Test plan
- Reset mid-load: assert `rst` after 3 of 8 bits → next cycle state IDLE, `key_out`=0, `fsm_rst`=1, `busy`=0.
- No macro, KEY_W=8, stream 0xA5 LSB first with no stalls → `key_out`=0xA5 and `key_ready`=1 nine edges after `load_start`; `fsm_rst`=0 one edge later.
- Stalls: 0x3C with `key_sdi_valid` low every other cycle → `key_out`=0x3C, and `key_out` stays 0 until commit.
- Restart: `load_start` together with valid bit 5, then a full stream of 0x0F → `key_out`=0x0F and the discarded bit has no effect.
- Macro, key 0xA5 with parity 0 → READY, `key_err`=0. Key 0xA5 with parity 1 → ERROR, `key_err`=1, `key_out`=0, `fsm_rst` held at 1.
- Reload from READY: `load_start` → `key_ready`=0, `fsm_rst`=1, `key_out`=0 after the same edge; new key 0x5A commits correctly.
